// File: rtl/line_raster.sv
// Bresenham line rasteriser: takes two endpoints and a colour, streams one
// pixel per cycle over a ready/valid port, steps diagonally when both axes
// advance, and suppresses points outside the CLIP_W x CLIP_H screen.
module line_raster #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 24,
  parameter int CLIP_W  = 160,
  parameter int CLIP_H  = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               pixel_last,
  output logic               done
);

  localparam int SW = COORD_W + 2;
  // One extra bit so a clip limit of 2^COORD_W is representable.
  localparam logic [COORD_W:0] CW_L = (COORD_W+1)'(CLIP_W);
  localparam logic [COORD_W:0] CH_L = (COORD_W+1)'(CLIP_H);

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   px_q, px_d, py_q, py_d;
  logic [COORD_W-1:0]   xe_q, xe_d, ye_q, ye_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                 sxn_q, sxn_d, syn_q, syn_d;
  logic                 valid_q, valid_d, last_q, last_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [COORD_W-1:0]   adx, ady, nx, ny;
  logic signed [SW:0]   e2, dx_ext, dy_ext;
  logic signed [SW-1:0] inc_x, inc_y;
  logic                 step_x, step_y, at_end, advance, nvalid;

  function automatic logic in_bounds(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return ({1'b0, x} < CW_L) && ({1'b0, y} < CH_L);
  endfunction

  // In INIT px/py still hold the start point, so these give |x1-x0|, |y1-y0|.
  assign adx = (xe_q >= px_q) ? xe_q - px_q : px_q - xe_q;
  assign ady = (ye_q >= py_q) ? ye_q - py_q : py_q - ye_q;

  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[SW-1], dx_q};
  assign dy_ext = {dy_q[SW-1], dy_q};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign inc_x  = step_x ? dy_q : SW'(0);
  assign inc_y  = step_y ? dx_q : SW'(0);
  assign nx     = step_x ? (sxn_q ? px_q - 1'b1 : px_q + 1'b1) : px_q;
  assign ny     = step_y ? (syn_q ? py_q - 1'b1 : py_q + 1'b1) : py_q;
  assign at_end = (px_q == xe_q) && (py_q == ye_q);
  // A clipped point never waits for the consumer.
  assign advance = !valid_q || pixel_ready;
  assign nvalid  = in_bounds(nx, ny);

  // Next-state and next-output computation for the whole FSM.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = INIT;
          px_d    = x0;
          py_d    = y0;
          xe_d    = x1;
          ye_d    = y1;
          color_d = color;
          busy_d  = 1'b1;
        end
      end
      INIT: begin
        dx_d    = $signed({2'b00, adx});
        dy_d    = -$signed({2'b00, ady});
        err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
        sxn_d   = !(px_q < xe_q);
        syn_d   = !(py_q < ye_q);
        valid_d = in_bounds(px_q, py_q);
        last_d  = in_bounds(px_q, py_q) && at_end;
        state_d = STEP;
      end
      STEP: begin
        if (advance) begin
          if (at_end) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            px_d    = nx;
            py_d    = ny;
            err_d   = err_q + inc_x + inc_y;
            valid_d = nvalid;
            last_d  = nvalid && (nx == xe_q) && (ny == ye_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any line in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign px          = px_q;
  assign py          = py_q;
  assign pixel_color = color_q;
  assign pixel_valid = valid_q;
  assign pixel_last  = last_q;
  assign done        = done_q;

endmodule
